uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver. Data width, oversampling ratio and FIFO depth are compile-time parameters. Baud divisor, parity mode and stop-bit count are run-time inputs. Each received frame is stored with per-frame parity/framing error flags in an internal first-word-fall-through FIFO, and lost frames are reported through a sticky overrun flag. It sits between the pad-side rx line and a host/bus register interface, replacing the fixed 9600-baud 8N1 receiver.

Parameters:
WIDTH, 8, data bits per frame (5..9)
OVS, 16, sample ticks per bit (even, >=4)
DEPTH, 16, FIFO entries (power of two, >=2)
DIV_W, 16, width of the baud divisor input

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  serial input, asynchronous to clk
div  in  DIV_W  clk cycles per sample tick minus 1
parity_mode  in  2  0 none, 1 even, 2 odd, 3 reserved (treated as none)
two_stop  in  1  1 = two stop bits
rd_en  in  1  pop FIFO head
clr_overrun  in  1  clears overrun
d_out  out  WIDTH  FIFO head data (FWFT)
d_perr  out  1  head frame parity error
d_ferr  out  1  head frame framing error
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(DEPTH)+1  FIFO occupancy
overrun  out  1  sticky: frame dropped because FIFO full
busy  out  1  FSM not IDLE

Behaviour:
- Reset values: empty=1, full=0, count=0, overrun=0, busy=0, d_out/d_perr/d_ferr=0. Synchroniser flops reset to 1. FSM resets to IDLE.
- Asserting reset mid-frame aborts the frame, empties the FIFO and clears all flags.
- rx passes through a 2-flop synchroniser; the FSM sees only the synchronised value (2-cycle latency).
- Tick generator: counter 0..div, tick pulses one cycle when counter==div, then counter wraps to 0.
  - div=0 gives a tick every cycle.
  - The counter free-runs and is not resynchronised to the start bit.
- Configuration (parity_mode, two_stop) is latched on start detection. Changes mid-frame have no effect until the next frame. div is used live and software changes it only while busy=0.
- FSM, sample counter s counting ticks:
  - IDLE: synchronised rx==0 -> START, s=0.
  - START: at s==OVS/2-1, sample. rx==1 -> IDLE (glitch, nothing stored). rx==0 -> DATA, s=0, bit index 0.
  - DATA: sample at s==OVS-1, LSB first, WIDTH bits -> PARITY if parity enabled, else STOP.
  - PARITY: one sample. perr = (XOR of data bits ^ sampled bit) != 0 for even, ==0 for odd.
  - STOP: one sample per stop bit. Any sampled 0 sets ferr. After the last stop sample -> IDLE in the same cycle the frame is pushed. A new start edge is therefore detectable from mid-stop-bit.
- Push: frame is written as {ferr, perr, data}.
  - If full and no simultaneous pop: frame is dropped and overrun is set.
  - Error frames are still stored; flags travel with the data.
- Pop: rd_en with !empty advances head next cycle. rd_en while empty is ignored.
  - Push and pop in the same cycle: both occur and count is unchanged. When full this is legal, with no overrun.
- d_out/d_perr/d_ferr show the head entry whenever !empty. Pointers wrap modulo DEPTH.
- overrun is cleared by clr_overrun. If a drop occurs in the same cycle as clr_overrun, set wins.
- busy=1 in every state except IDLE.

Optional Feature:
UART_RX_TIMEOUT_EN
- Defined: adds output rx_timeout (1 bit) and parameter TO_BITS (default 4).
  - An idle counter counts ticks while the FSM is IDLE and the FIFO is non-empty.
  - rx_timeout asserts when the counter reaches TO_BITS*OVS ticks.
  - It clears, together with the counter, on any start detection, pop, or empty FIFO. Reset value 0.
- Undefined: no port, no counter, no parameter effect.

Decomposition:
- Package uart_rx_pkg:
  - parity_mode encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - Entry-width helper constant ENTRY_W = WIDTH+2.
- Sub-module uart_rx_fifo: parametrised FWFT FIFO (ENTRY_W, DEPTH) with count. Tick generator, synchroniser and FSM stay in the top.

Test Plan:
- Reset, then div=3, OVS=16, parity none, 1 stop; send 0xA5 -> after ~10*64 clocks: empty=0, count=1, d_out=0xA5, perr=ferr=0; rd_en for 1 cycle -> empty=1.
- parity_mode=1 (even); send 0x03 with parity bit 1 -> d_out=0x03, d_perr=1. Same byte with parity bit 0 -> d_perr=0.
- two_stop=1; send 0x5A with second stop bit driven 0 -> d_ferr=1, data 0x5A stored. Next frame 0x11 clean -> d_ferr=0.
- rx low for 3 ticks then high -> returns to IDLE, count stays 0, busy pulses then drops.
- DEPTH=16: send 17 frames without reads -> full=1, count=16, overrun=1, head=frame 1. clr_overrun -> overrun=0. A 17th push coincident with rd_en -> count stays 16, overrun stays 0.
- With UART_RX_TIMEOUT_EN, TO_BITS=4: one frame, then idle -> rx_timeout=1 after 64 ticks. rd_en -> rx_timeout=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared encodings and helpers for the configurable UART receiver
package uart_rx_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // FIFO entry carries {ferr, perr, data}
    function automatic int entry_w(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through FIFO with occupancy count
module uart_rx_fifo #(
    parameter int ENTRY_W = 10,
    parameter int DEPTH   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [ENTRY_W-1:0]       i_wr_data,
    input  logic                     i_rd_en,
    output logic [ENTRY_W-1:0]       o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               w_pop;
    logic               w_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // A write into a full FIFO is accepted only when the head leaves in the same cycle
    assign w_pop  = i_rd_en && !o_empty;
    assign w_push = i_wr_en && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable UART receiver with FWFT frame FIFO
// Optional idle-timeout output enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_cfg
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OVS   = 16,
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
`ifdef UART_RX_TIMEOUT_EN
    ,
    parameter int TO_BITS = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    input  logic [DIV_W-1:0]       div,
    input  logic [1:0]             parity_mode,
    input  logic                   two_stop,
    input  logic                   rd_en,
    input  logic                   clr_overrun,
    output logic [WIDTH-1:0]       d_out,
    output logic                   d_perr,
    output logic                   d_ferr,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    output logic                   busy
`ifdef UART_RX_TIMEOUT_EN
    ,
    output logic                   rx_timeout
`endif
);

    localparam int ENTRY_W = entry_w(WIDTH);
    localparam int SW      = $clog2(OVS);
    localparam int BW      = $clog2(WIDTH);
    localparam logic [SW-1:0] S_HALF = SW'(OVS/2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);

    logic               r_rx_meta;
    logic               r_rx_sync;
    logic [DIV_W-1:0]   r_tick_cnt;
    logic               w_tick;
    rx_state_t          r_state;
    logic [SW-1:0]      r_s;
    logic [BW-1:0]      r_bit_idx;
    logic [WIDTH-1:0]   r_data;
    logic [1:0]         r_pmode;
    logic               r_two_stop;
    logic               r_stop_idx;
    logic               r_perr;
    logic               r_ferr;
    logic               r_push;
    logic [ENTRY_W-1:0] r_push_data;
    logic               r_overrun;
    logic [ENTRY_W-1:0] w_head;
    logic               w_par_en;
    logic               w_start_det;
    logic               w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Free-running baud tick; deliberately not realigned to the start edge
    assign w_tick = (r_tick_cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + DIV_W'(1);
        end
    end

    assign w_par_en    = (r_pmode == PAR_EVEN) || (r_pmode == PAR_ODD);
    assign w_start_det = (r_state == IDLE) && !r_rx_sync;
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_bit_idx   <= '0;
            r_data      <= '0;
            r_pmode     <= PAR_NONE;
            r_two_stop  <= 1'b0;
            r_stop_idx  <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_det) begin
                        r_state    <= START;
                        r_s        <= '0;
                        r_pmode    <= parity_mode;
                        r_two_stop <= two_stop;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_s == S_HALF) begin
                            r_s       <= '0;
                            r_bit_idx <= '0;
                            r_state   <= r_rx_sync ? IDLE : DATA;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_s == S_LAST) begin
                            r_s        <= '0;
                            r_data     <= {r_rx_sync, r_data[WIDTH-1:1]};
                            r_bit_idx  <= r_bit_idx + BW'(1);
                            r_stop_idx <= 1'b0;
                            if (r_bit_idx == BW'(WIDTH - 1)) begin
                                r_state <= w_par_en ? PARITY : STOP;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        if (r_s == S_LAST) begin
                            r_s     <= '0;
                            r_perr  <= (^r_data) ^ r_rx_sync ^ (r_pmode == PAR_ODD);
                            r_state <= STOP;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_s == S_LAST) begin
                            r_s <= '0;
                            if (r_two_stop && !r_stop_idx) begin
                                r_stop_idx <= 1'b1;
                                r_ferr     <= r_ferr | !r_rx_sync;
                            end else begin
                                r_state     <= IDLE;
                                r_push      <= 1'b1;
                                r_push_data <= {r_ferr | !r_rx_sync, r_perr, r_data};
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (r_push),
        .i_wr_data (r_push_data),
        .i_rd_en   (rd_en),
        .o_rd_data (w_head),
        .o_empty   (empty),
        .o_full    (full),
        .o_count   (count)
    );

    assign {d_ferr, d_perr, d_out} = w_head;

    assign w_drop  = r_push && full && !rd_en;
    assign overrun = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TO_BITS * OVS;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    logic [TW-1:0] r_idle_cnt;
    logic          r_timeout;

    assign rx_timeout = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_start_det || (rd_en && !empty) || empty) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if ((r_state == IDLE) && w_tick && !r_timeout) begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
            if (r_idle_cnt == TW'(TO_LIMIT - 1)) begin
                r_timeout <= 1'b1;
            end
        end
    end
`endif

endmodule
